// File: rtl/rcb_spi_bus_ctrl_if.sv
// RCB internal register bus: one controller (master) drives a cycle,
// the addressed register block (slave) answers with ack and read data.
interface rcb_spi_bus_ctrl_if;
    logic        bus_cs;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_cs, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_cs, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/rcb_spi_bus_ctrl.sv
// RCB register bus controller: arbitrates the internal register bus between
// the SPI slave front end (always first) and one local requester, runs a
// single outstanding cycle bounded by an ack timeout, and returns read data.
// Optional feature macro: RCB_BUS_ERR_CNT_EN builds a saturating timeout
// counter on err_cnt; without it err_cnt is tied to zero.
module rcb_spi_bus_ctrl #(
    parameter int unsigned ACK_TIMEOUT  = 15,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
    input  logic                       clk_100m,
    input  logic                       rst_n,
    input  logic [15:0]                spi_addr,
    input  logic                       spi_addr_rdy,
    input  logic                       spi_read,
    input  logic [31:0]                spi_wdata,
    input  logic                       spi_wdata_rdy,
    output logic [31:0]                spi_rdata,
    input  logic                       loc_req,
    input  logic                       loc_we,
    input  logic [15:0]                loc_addr,
    input  logic [31:0]                loc_wdata,
    output logic [31:0]                loc_rdata,
    output logic                       loc_done,
    rcb_spi_bus_ctrl_if.master         bus,
    output logic                       bus_timeout,
    output logic [15:0]                err_cnt
);

    typedef enum logic [2:0] {IDLE, SPI_RD, SPI_WR, LOC, WAIT_ACK} state_t;

    // Timer counts WAIT_ACK cycles from 0; the first bus_cs cycle is not
    // counted, so the last allowed cycle is reached at ACK_TIMEOUT-2.
    localparam logic [7:0] TMR_LAST  = (ACK_TIMEOUT >= 2) ? 8'(ACK_TIMEOUT - 2) : 8'd0;
    localparam logic       ONE_CYCLE = (ACK_TIMEOUT <= 1);

    state_t      state, state_nxt;
    logic        rd_pend, wr_pend, lat_pend;
    logic [15:0] addr_lat;
    logic [31:0] wdata_lat;
    logic [7:0]  tmr;
    logic        hold_we, hold_spi_rd, hold_loc;
    logic [15:0] hold_addr;
    logic [31:0] hold_wdata;

    logic        cs, we, first, done_ok, done_to, cur_spi_rd, cur_loc, loc_ok;
    logic [15:0] addr;
    logic [31:0] wdata;

    assign bus.bus_cs    = cs;
    assign bus.bus_we    = we;
    assign bus.bus_addr  = addr;
    assign bus.bus_wdata = wdata;

    // State register.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Arbitration, bus drive and cycle completion/timeout decisions.
    always_comb begin
        state_nxt  = state;
        cs         = 1'b0;
        we         = 1'b0;
        addr       = 16'h0000;
        wdata      = 32'h0000_0000;
        first      = 1'b0;
        done_ok    = 1'b0;
        done_to    = 1'b0;
        cur_spi_rd = 1'b0;
        cur_loc    = 1'b0;
        // An SPI pulse arriving this cycle blocks a local grant so SPI wins
        // even though its pend flag only becomes visible next cycle; loc_done
        // masks the requester's still-high loc_req for one cycle.
        loc_ok = loc_req && !loc_done && !spi_addr_rdy && !spi_wdata_rdy;
        case (state)
            IDLE: begin
                if (rd_pend)      state_nxt = SPI_RD;
                else if (wr_pend) state_nxt = SPI_WR;
                else if (loc_ok)  state_nxt = LOC;
            end
            SPI_RD: begin
                cs = 1'b1; addr = addr_lat; first = 1'b1; cur_spi_rd = 1'b1;
            end
            SPI_WR: begin
                cs = 1'b1; we = 1'b1; addr = addr_lat; wdata = wdata_lat; first = 1'b1;
            end
            LOC: begin
                cs = 1'b1; we = loc_we; addr = loc_addr; wdata = loc_wdata;
                first = 1'b1; cur_loc = 1'b1;
            end
            WAIT_ACK: begin
                cs = 1'b1; we = hold_we; addr = hold_addr; wdata = hold_wdata;
                cur_spi_rd = hold_spi_rd; cur_loc = hold_loc;
            end
            default: state_nxt = IDLE;
        endcase
        if (cs) begin
            if (bus.bus_ack) begin
                done_ok   = 1'b1;
                state_nxt = IDLE;
            end else if (first ? ONE_CYCLE : (tmr >= TMR_LAST)) begin
                done_to   = 1'b1;
                state_nxt = IDLE;
            end else if (first) begin
                state_nxt = WAIT_ACK;
            end
        end
    end

    // SPI capture: pend flags (set wins over service clear) and address latch.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend  <= 1'b0;
            wr_pend  <= 1'b0;
            lat_pend <= 1'b0;
            addr_lat <= 16'hFFFF;
        end else begin
            if (spi_addr_rdy && spi_read) rd_pend <= 1'b1;
            else if (state == SPI_RD)     rd_pend <= 1'b0;
            if (spi_wdata_rdy)            wr_pend <= 1'b1;
            else if (state == SPI_WR)     wr_pend <= 1'b0;
            lat_pend <= spi_addr_rdy;
            if (lat_pend) addr_lat <= spi_addr;
        end
    end

    // SPI write data latch and per-cycle hold of address/data/source.
    always_ff @(posedge clk_100m) begin
        if (spi_wdata_rdy) wdata_lat <= spi_wdata;
        if (first) begin
            hold_we     <= we;
            hold_addr   <= addr;
            hold_wdata  <= wdata;
            hold_spi_rd <= cur_spi_rd;
            hold_loc    <= cur_loc;
        end
    end

    // Ack timer and completion outputs.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            tmr         <= 8'd0;
            spi_rdata   <= 32'hFFFF_FFFF;
            loc_rdata   <= 32'h0000_0000;
            loc_done    <= 1'b0;
            bus_timeout <= 1'b0;
        end else begin
            if (first)                  tmr <= 8'd0;
            else if (state == WAIT_ACK) tmr <= tmr + 8'd1;
            loc_done    <= (done_ok || done_to) && cur_loc;
            bus_timeout <= done_to;
            if ((done_ok || done_to) && cur_spi_rd)
                spi_rdata <= done_ok ? bus.bus_rdata : TIMEOUT_DATA;
            if ((done_ok || done_to) && cur_loc && !we)
                loc_rdata <= done_ok ? bus.bus_rdata : TIMEOUT_DATA;
        end
    end

`ifdef RCB_BUS_ERR_CNT_EN
    // Saturating count of timed-out bus cycles.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n)                              err_cnt <= 16'h0000;
        else if (done_to && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
`else
    assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rcb_spi_bus_ctrl.sv
// Scoreboard bench for rcb_spi_bus_ctrl: stimulus pushes the expected bus
// cycle and its response; a negedge monitor pops and checks each cycle.
module tb_rcb_spi_bus_ctrl;

    logic        clk_100m = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] spi_addr = 16'h0;
    logic        spi_addr_rdy = 1'b0;
    logic        spi_read = 1'b0;
    logic [31:0] spi_wdata = 32'h0;
    logic        spi_wdata_rdy = 1'b0;
    logic [31:0] spi_rdata;
    logic        loc_req = 1'b0;
    logic        loc_we = 1'b0;
    logic [15:0] loc_addr = 16'h0;
    logic [31:0] loc_wdata = 32'h0;
    logic [31:0] loc_rdata;
    logic        loc_done;
    logic        bus_timeout;
    logic [15:0] err_cnt;

    rcb_spi_bus_ctrl_if bus_if();

    rcb_spi_bus_ctrl dut (
        .clk_100m(clk_100m), .rst_n(rst_n),
        .spi_addr(spi_addr), .spi_addr_rdy(spi_addr_rdy), .spi_read(spi_read),
        .spi_wdata(spi_wdata), .spi_wdata_rdy(spi_wdata_rdy), .spi_rdata(spi_rdata),
        .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
        .loc_rdata(loc_rdata), .loc_done(loc_done),
        .bus(bus_if.master),
        .bus_timeout(bus_timeout), .err_cnt(err_cnt)
    );

    always #5 clk_100m = ~clk_100m;

    // Register-bus slave model: fixed read table, programmable ack delay.
    logic ack_en = 1'b1;
    int   ack_dly = 0;
    int   cs_age = 0;
    int   cyc = 0;

    function automatic logic [31:0] slave_table(input logic [15:0] a);
        case (a)
            16'h0010: return 32'h12345678;
            16'h0020: return 32'h20202020;
            16'h0024: return 32'h24242424;
            16'h0030: return 32'hCAFEF00D;
            16'h0040: return 32'h0BEEF040;
            16'h0100: return 32'h5A5A0100;
            default:  return 32'h00000000;
        endcase
    endfunction

    assign bus_if.bus_rdata = slave_table(bus_if.bus_addr);
    assign bus_if.bus_ack   = bus_if.bus_cs && ack_en && (cs_age >= ack_dly);

    always @(posedge clk_100m) begin
        cyc <= cyc + 1;
        if (!rst_n || !bus_if.bus_cs) cs_age <= 0;
        else                          cs_age <= cs_age + 1;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          ncyc;
        logic        spi_rd;
        logic        loc;
        logic        to;
        logic [31:0] rdata;
        int          start;
        int          err;
    } exp_t;

    exp_t q[$];
    int   pending = 0;
    int   exp_err = 0;

    task automatic push(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                        input int ncyc, input logic spi_rd, input logic loc, input logic to,
                        input logic [31:0] rdata, input int start);
        exp_t e;
`ifdef RCB_BUS_ERR_CNT_EN
        if (to) exp_err++;
`endif
        e.we = we; e.addr = addr; e.wdata = wdata; e.ncyc = ncyc; e.spi_rd = spi_rd;
        e.loc = loc; e.to = to; e.rdata = rdata; e.start = start; e.err = exp_err;
        q.push_back(e);
        pending++;
    endtask

    // Monitor: checks each bus cycle against the scoreboard head.
    exp_t cur;
    logic active = 1'b0;
    logic prev_cs = 1'b0;
    int   ncyc = 0;

    always @(negedge clk_100m) begin
        if (!rst_n) begin
            if (active) pending--;
            active  = 1'b0;
            prev_cs = 1'b0;
        end else begin
            if (bus_if.bus_cs && !prev_cs) begin
                if (q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_bus_cycle: got addr %h required no cycle", bus_if.bus_addr);
                end else begin
                    cur    = q.pop_front();
                    active = 1'b1;
                    ncyc   = 1;
                    chk("bus_we", {31'b0, bus_if.bus_we}, {31'b0, cur.we});
                    chk("bus_addr", {16'b0, bus_if.bus_addr}, {16'b0, cur.addr});
                    if (cur.we) chk("bus_wdata", bus_if.bus_wdata, cur.wdata);
                    if (cur.start >= 0) chk("start_cycle", cyc, cur.start);
                end
            end else if (bus_if.bus_cs && prev_cs && active) begin
                ncyc++;
                chk("addr_stable", {16'b0, bus_if.bus_addr}, {16'b0, cur.addr});
            end
            if (!bus_if.bus_cs && prev_cs && active) begin
                active = 1'b0;
                pending--;
                chk("cs_cycles", ncyc, cur.ncyc);
                chk("bus_timeout", {31'b0, bus_timeout}, {31'b0, cur.to});
                chk("loc_done", {31'b0, loc_done}, {31'b0, cur.loc});
                chk("err_cnt", {16'b0, err_cnt}, cur.err);
                if (cur.spi_rd) chk("spi_rdata", spi_rdata, cur.rdata);
                if (cur.loc && !cur.we) chk("loc_rdata", loc_rdata, cur.rdata);
            end else begin
                if (loc_done) begin
                    n_chk++; n_fail++;
                    $display("FAIL spurious_loc_done: got 1 required 0");
                end
                if (bus_timeout) begin
                    n_chk++; n_fail++;
                    $display("FAIL spurious_bus_timeout: got 1 required 0");
                end
            end
            prev_cs = bus_if.bus_cs;
        end
    end

    task automatic spi_rd(input logic [15:0] a, output int t0);
        @(posedge clk_100m); #1;
        t0 = cyc;
        spi_addr_rdy = 1'b1; spi_read = 1'b1; spi_addr = 16'hBAD0;
        @(posedge clk_100m); #1;
        spi_addr_rdy = 1'b0; spi_read = 1'b0; spi_addr = a;
    endtask

    task automatic spi_wr_addr(input logic [15:0] a);
        @(posedge clk_100m); #1;
        spi_addr_rdy = 1'b1; spi_read = 1'b0; spi_addr = 16'hBAD0;
        @(posedge clk_100m); #1;
        spi_addr_rdy = 1'b0; spi_addr = a;
    endtask

    task automatic spi_data(input logic [31:0] d);
        @(posedge clk_100m); #1;
        spi_wdata_rdy = 1'b1; spi_wdata = d;
        @(posedge clk_100m); #1;
        spi_wdata_rdy = 1'b0; spi_wdata = 32'h0;
    endtask

    // Local requester: holds loc_req until loc_done (or reset) is seen.
    task automatic loc_wait();
        logic got = 1'b0;
        logic aborted = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_100m);
            if (!rst_n) begin aborted = 1'b1; break; end
            if (loc_done) begin got = 1'b1; break; end
        end
        loc_req = 1'b0;
        if (!got && !aborted) begin
            n_chk++; n_fail++;
            $display("FAIL loc_done_wait: got no loc_done required one within 400 cycles");
        end
    endtask

    task automatic loc_start(input logic we, input logic [15:0] a, input logic [31:0] d);
        loc_we = we; loc_addr = a; loc_wdata = d; loc_req = 1'b1;
        fork
            loc_wait();
        join_none
    endtask

    task automatic wait_quiet();
        logic ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_100m);
            if (pending == 0 && !loc_req && !bus_if.bus_cs) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL quiet_wait: got pending=%0d required 0", pending);
        end
        repeat (2) @(posedge clk_100m);
    endtask

    task automatic wait_cs();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_100m);
            if (bus_if.bus_cs) break;
        end
    endtask

    initial begin
        repeat (20000) @(posedge clk_100m);
        $display("FAIL watchdog: got no end of test required finish within 20000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        // Reset state.
        repeat (3) @(posedge clk_100m);
        #2;
        chk("rst_bus_cs", {31'b0, bus_if.bus_cs}, 32'd0);
        chk("rst_spi_rdata", spi_rdata, 32'hFFFFFFFF);
        chk("rst_loc_done", {31'b0, loc_done}, 32'd0);
        chk("rst_loc_rdata", loc_rdata, 32'd0);
        chk("rst_err_cnt", {16'b0, err_cnt}, 32'd0);
        chk("rst_bus_timeout", {31'b0, bus_timeout}, 32'd0);
        @(posedge clk_100m); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk_100m);

        // SPI read, zero-wait ack: bus_cs at T2, data at T3.
        spi_rd(16'h0010, t0);
        push(1'b0, 16'h0010, 32'h0, 1, 1'b1, 1'b0, 1'b0, 32'h12345678, t0 + 2);
        wait_quiet();

        // SPI write, zero-wait.
        spi_wr_addr(16'h0004);
        push(1'b1, 16'h0004, 32'hA5A5A5A5, 1, 1'b0, 1'b0, 1'b0, 32'h0, -1);
        spi_data(32'hA5A5A5A5);
        wait_quiet();
        chk("spi_rdata_hold", spi_rdata, 32'h12345678);

        // SPI write with 3 wait states.
        ack_dly = 3;
        spi_wr_addr(16'h0008);
        push(1'b1, 16'h0008, 32'h0BADF00D, 4, 1'b0, 1'b0, 1'b0, 32'h0, -1);
        spi_data(32'h0BADF00D);
        wait_quiet();

        // SPI read with 2 wait states.
        ack_dly = 2;
        spi_rd(16'h0030, t0);
        push(1'b0, 16'h0030, 32'h0, 3, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D, t0 + 2);
        wait_quiet();

        // Local request and SPI read pulse in the same cycle: SPI first.
        ack_dly = 0;
        push(1'b0, 16'h0040, 32'h0, 1, 1'b1, 1'b0, 1'b0, 32'h0BEEF040, -1);
        push(1'b0, 16'h0100, 32'h0, 1, 1'b0, 1'b1, 1'b0, 32'h5A5A0100, -1);
        @(posedge clk_100m); #1;
        loc_start(1'b0, 16'h0100, 32'h0);
        spi_addr_rdy = 1'b1; spi_read = 1'b1; spi_addr = 16'hBAD0;
        @(posedge clk_100m); #1;
        spi_addr_rdy = 1'b0; spi_read = 1'b0; spi_addr = 16'h0040;
        wait_quiet();

        // Local write, one wait state.
        ack_dly = 1;
        push(1'b1, 16'h0200, 32'h11223344, 2, 1'b0, 1'b1, 1'b0, 32'h0, -1);
        @(posedge clk_100m); #1;
        loc_start(1'b1, 16'h0200, 32'h11223344);
        wait_quiet();

        // Local read never acked: 15 bus_cs cycles, timeout data.
        ack_en = 1'b0;
        push(1'b0, 16'h0300, 32'h0, 15, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, -1);
        @(posedge clk_100m); #1;
        loc_start(1'b0, 16'h0300, 32'h0);
        wait_quiet();
        ack_en = 1'b1;

        // Two SPI reads behind a long local write: only the latest issues.
        ack_dly = 6;
        push(1'b1, 16'h0400, 32'h99887766, 7, 1'b0, 1'b1, 1'b0, 32'h0, -1);
        push(1'b0, 16'h0024, 32'h0, 7, 1'b1, 1'b0, 1'b0, 32'h24242424, -1);
        @(posedge clk_100m); #1;
        loc_start(1'b1, 16'h0400, 32'h99887766);
        wait_cs();
        spi_rd(16'h0020, t0);
        spi_rd(16'h0024, t0);
        wait_quiet();

        // Reset during WAIT_ACK of a local read.
        ack_en = 1'b0;
        ack_dly = 0;
        push(1'b0, 16'h0500, 32'h0, 15, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, -1);
        @(posedge clk_100m); #1;
        loc_start(1'b0, 16'h0500, 32'h0);
        wait_cs();
        repeat (3) @(posedge clk_100m);
        #3 rst_n = 1'b0;
        exp_err = 0;
        #1;
        chk("midrst_bus_cs", {31'b0, bus_if.bus_cs}, 32'd0);
        chk("midrst_spi_rdata", spi_rdata, 32'hFFFFFFFF);
        chk("midrst_loc_done", {31'b0, loc_done}, 32'd0);
        chk("midrst_err_cnt", {16'b0, err_cnt}, 32'd0);
        repeat (2) @(posedge clk_100m);
        #1 rst_n = 1'b1;
        ack_en = 1'b1;
        repeat (6) @(negedge clk_100m);
        chk("postrst_idle", {31'b0, bus_if.bus_cs}, 32'd0);
        chk("postrst_pending", pending, 32'd0);

        // Write data with no address after reset goes to 16'hFFFF.
        push(1'b1, 16'hFFFF, 32'h0F0F0F0F, 1, 1'b0, 1'b0, 1'b0, 32'h0, -1);
        spi_data(32'h0F0F0F0F);
        wait_quiet();
        chk("final_queue_empty", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
